// File: rtl/minimig_sram_responder.sv
// minimig_sram_responder: turns SRAM-style strobes into req/ack backing-memory transactions (optional read cache: MINIMIG_SRAM_RDCACHE_EN)
module minimig_sram_responder #(
  parameter int SETTLE = 1,
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          _we,
  input  logic          _oe,
  input  logic          _bhe,
  input  logic          _ble,
  input  logic [21:0]   address,
  input  logic [15:0]   data,
  output logic [15:0]   ramdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  output logic          busy,
  output logic          late
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [25:0] snap;
  logic rel;
  logic active, accept, hit;
  logic [25:0] cur;
  logic [1:0] cnt_nx, be;
  assign active = !_we || !_oe;
  assign cur = {_we, _oe, _bhe, _ble, address};
  assign cnt_nx = (cnt != 2'd0 && cur == snap) ? cnt + 2'd1 : 2'd1;
  assign accept = active && cnt_nx >= 2'(SETTLE);
  assign be = {!_bhe, !_ble};
`ifdef MINIMIG_SRAM_RDCACHE_EN
  logic [AW-1:0] tag;
  logic valid;
  assign hit = _we && valid && tag == address[AW-1:0];
  always_ff @(posedge clk)
    if (reset) valid <= 1'b0;
    else if (state == IDLE && accept && !_we && tag == address[AW-1:0]) valid <= 1'b0;
    else if (state == REQ && mem_ack && !mem_we) begin
      valid <= 1'b1;
      tag <= mem_addr;
    end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= 2'd0;
      snap <= '0;
      rel <= 1'b0;
      ramdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= 2'b00;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      late <= 1'b0;
    end else
      case (state)
        IDLE: begin
          cnt <= (active && !accept) ? cnt_nx : 2'd0;
          snap <= cur;
          if (accept) begin
            mem_we <= !_we;
            mem_be <= !_we ? be : 2'b11;
            mem_addr <= address[AW-1:0];
            mem_wdata <= data;
            rel <= 1'b0;
            // null writes and cache hits need no backend cycle
            if ((!_we && be == 2'b00) || hit) state <= HOLD;
            else begin
              state <= REQ;
              mem_req <= 1'b1;
              busy <= 1'b1;
            end
          end
        end
        REQ: begin
          if (_we && _oe) begin
            rel <= 1'b1;
            late <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy <= 1'b0;
            if (!mem_we) ramdata <= mem_rdata;
            state <= (rel || (_we && _oe)) ? IDLE : HOLD;
          end
        end
        HOLD: if (_we && _oe) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_minimig_sram_responder.sv
// tb_minimig_sram_responder: scoreboard bench for the SRAM responder
module tb_minimig_sram_responder;
  logic clk = 0, reset = 1;
  logic _we = 1, _oe = 1, _bhe = 1, _ble = 1;
  logic [21:0] address = '0;
  logic [15:0] data = '0, ramdata, mem_wdata, mem_rdata = '0;
  logic mem_req, mem_we, mem_ack = 0, busy, late;
  logic [1:0] mem_be;
  logic [21:0] mem_addr;
  int checks = 0, passed = 0;
  typedef struct packed {logic we; logic [1:0] be; logic [21:0] addr; logic [15:0] wdata;} txn_t;
  txn_t exp_q[$];

  minimig_sram_responder #(.SETTLE(1), .AW(22)) dut (
    .clk(clk), .reset(reset), ._we(_we), ._oe(_oe), ._bhe(_bhe), ._ble(_ble),
    .address(address), .data(data), .ramdata(ramdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .late(late)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end

  task automatic drive(input logic we, oe, bhe, ble, input logic [21:0] a, input logic [15:0] d);
    _we = we; _oe = oe; _bhe = bhe; _ble = ble; address = a; data = d;
  endtask

  task automatic release_bus();
    _we = 1; _oe = 1;
    repeat (2) @(negedge clk);
  endtask

  // acts as backend: waits for a request, checks it against the scoreboard, acks after delay cycles
  task automatic serve(input int delay, input logic [15:0] rd, input bit early);
    int n, hi;
    txn_t got, e;
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      $display("FAIL req_timeout: mem_req=%b required 1", mem_req);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    passed++;
    got = '{mem_we, mem_be, mem_addr, mem_wdata};
    checks++;
    if (exp_q.size() == 0) $display("FAIL txn_unexpected: got %h, none required", got);
    else begin
      e = exp_q.pop_front();
      if (got !== e) $display("FAIL txn: got we=%b be=%b addr=%h wdata=%h required we=%b be=%b addr=%h wdata=%h",
                              got.we, got.be, got.addr, got.wdata, e.we, e.be, e.addr, e.wdata);
      else passed++;
    end
    if (early) begin _we = 1; _oe = 1; end
    hi = 0;
    repeat (delay) begin
      @(negedge clk);
      if (mem_req === 1'b1 && busy === 1'b1) hi++;
    end
    checks++;
    if (hi !== delay) $display("FAIL req_held: high for %0d cycles required %0d", hi, delay);
    else passed++;
    mem_rdata = rd; mem_ack = 1;
    @(negedge clk);
    mem_ack = 0; mem_rdata = 16'h0000;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL req_drop: mem_req=%b busy=%b required 0 0", mem_req, busy);
    else passed++;
  endtask

  task automatic count_idle_reqs(input string name);
    int hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req !== 1'b0) hi++;
    end
    checks++;
    if (hi !== 0) $display("FAIL %s: mem_req high %0d cycles required 0", name, hi);
    else passed++;
  endtask

  task automatic test_reset();
    checks++;
    if (ramdata !== 16'h0000 || mem_req !== 0 || busy !== 0 || late !== 0 || mem_be !== 2'b00 || mem_addr !== '0)
      $display("FAIL reset: ramdata=%h req=%b busy=%b late=%b be=%b addr=%h required 0000 0 0 0 00 0",
               ramdata, mem_req, busy, late, mem_be, mem_addr);
    else passed++;
  endtask

  task automatic test_read();
    drive(1, 0, 0, 0, 22'h012345, 16'h0000);
    exp_q.push_back('{1'b0, 2'b11, 22'h012345, 16'h0000});
    serve(3, 16'hBEEF, 0);
    checks++;
    if (ramdata !== 16'hBEEF) $display("FAIL read_data: ramdata=%h required BEEF", ramdata);
    else passed++;
    release_bus();
    checks++;
    if (mem_req !== 0 || busy !== 0) $display("FAIL read_idle: req=%b busy=%b required 0 0", mem_req, busy);
    else passed++;
  endtask

  task automatic test_write();
    drive(0, 1, 0, 1, 22'h000010, 16'hA55A);
    exp_q.push_back('{1'b1, 2'b10, 22'h000010, 16'hA55A});
    serve(1, 16'h0000, 0);
    count_idle_reqs("write_no_repeat");
    checks++;
    if (ramdata !== 16'hBEEF || busy !== 0) $display("FAIL write_hold: ramdata=%h busy=%b required BEEF 0", ramdata, busy);
    else passed++;
    release_bus();
  endtask

  task automatic test_priority_null();
    drive(0, 0, 0, 0, 22'h000007, 16'h1357);
    exp_q.push_back('{1'b1, 2'b11, 22'h000007, 16'h1357});
    serve(2, 16'hFFFF, 0);
    checks++;
    if (ramdata !== 16'hBEEF) $display("FAIL both_low_is_write: ramdata=%h required BEEF", ramdata);
    else passed++;
    release_bus();
    drive(0, 1, 1, 1, 22'h000020, 16'h2468);
    count_idle_reqs("null_write");
    release_bus();
  endtask

  task automatic test_late();
    checks++;
    if (late !== 0) $display("FAIL late_pre: late=%b required 0", late);
    else passed++;
    drive(1, 0, 0, 0, 22'h000055, 16'h0000);
    exp_q.push_back('{1'b0, 2'b11, 22'h000055, 16'h0000});
    serve(5, 16'h5555, 1);
    checks++;
    if (late !== 1 || ramdata !== 16'h5555) $display("FAIL late_done: late=%b ramdata=%h required 1 5555", late, ramdata);
    else passed++;
    drive(1, 0, 0, 0, 22'h000200, 16'h0000);
    exp_q.push_back('{1'b0, 2'b11, 22'h000200, 16'h0000});
    serve(2, 16'h1234, 0);
    checks++;
    if (ramdata !== 16'h1234 || late !== 1) $display("FAIL late_next: ramdata=%h late=%b required 1234 1", ramdata, late);
    else passed++;
    release_bus();
  endtask

  task automatic test_cache();
    drive(1, 0, 0, 0, 22'h000100, 16'h0000);
    exp_q.push_back('{1'b0, 2'b11, 22'h000100, 16'h0000});
    serve(1, 16'hCAFE, 0);
    release_bus();
    drive(1, 0, 0, 0, 22'h000100, 16'h0000);
`ifdef MINIMIG_SRAM_RDCACHE_EN
    count_idle_reqs("cache_hit");
    checks++;
    if (ramdata !== 16'hCAFE) $display("FAIL cache_data: ramdata=%h required CAFE", ramdata);
    else passed++;
`else
    exp_q.push_back('{1'b0, 2'b11, 22'h000100, 16'h0000});
    serve(1, 16'hC0DE, 0);
    checks++;
    if (ramdata !== 16'hC0DE) $display("FAIL reread_data: ramdata=%h required C0DE", ramdata);
    else passed++;
`endif
    release_bus();
    drive(0, 1, 0, 0, 22'h000100, 16'h7777);
    exp_q.push_back('{1'b1, 2'b11, 22'h000100, 16'h7777});
    serve(1, 16'h0000, 0);
    release_bus();
    drive(1, 0, 0, 0, 22'h000100, 16'h0000);
    exp_q.push_back('{1'b0, 2'b11, 22'h000100, 16'h0000});
    serve(1, 16'hD00D, 0);
    checks++;
    if (ramdata !== 16'hD00D) $display("FAIL cache_invalidate: ramdata=%h required D00D", ramdata);
    else passed++;
    release_bus();
  endtask

  task automatic test_reset_abort();
    int n = 0;
    drive(1, 0, 0, 0, 22'h000300, 16'h0000);
    while (mem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reset = 1; _we = 1; _oe = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if (mem_req !== 0 || busy !== 0 || late !== 0 || ramdata !== 16'h0000 || mem_be !== 2'b00)
      $display("FAIL reset_abort: req=%b busy=%b late=%b ramdata=%h be=%b required 0 0 0 0000 00",
               mem_req, busy, late, ramdata, mem_be);
    else passed++;
    count_idle_reqs("reset_quiet");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_priority_null();
    test_late();
    test_cache();
    test_reset_abort();
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
